// File: rtl/core_pkg.sv
// Shared types and constants for the RV32 ALU control sequencer.
package core_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StWriteback,
    StHalt
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0]  OPCODE_OP        = 7'b0110011;
  localparam logic [31:0] INSTR_ECALL      = 32'h0000_0073;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction-memory valid/ready fetch channel.
interface core_sequencer_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instr_decoder.sv
// Combinational RV32 R-type ALU decoder; flags ECALL and a non-x0 destination.
module instr_decoder
  import core_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic        is_legal,
  output logic        is_ecall,
  output logic        rd_nonzero
);
  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  assign opcode     = instr[6:0];
  assign funct3     = instr[14:12];
  assign funct7     = instr[31:25];
  assign is_ecall   = (instr == INSTR_ECALL);
  assign rd_nonzero = (instr[11:7] != 5'd0);

  always_comb begin
    alu_op   = ALU_ADD;
    is_legal = 1'b0;
    if (opcode == OPCODE_OP) begin
      if (funct7 == 7'b0000000) begin
        is_legal = 1'b1;
        unique case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = ALU_SRL;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
        endcase
      end else if (funct7 == 7'b0100000) begin
        // Only SUB and SRA have an alternate-funct7 form.
        if (funct3 == 3'b000) begin
          is_legal = 1'b1;
          alu_op   = ALU_SUB;
        end else if (funct3 == 3'b101) begin
          is_legal = 1'b1;
          alu_op   = ALU_SRA;
        end
      end
    end
  end
endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback control FSM; owns PC and retired count.
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  core_sequencer_if.master    imem,
  output logic [31:0]         instr,
  output logic [3:0]          alu_op,
  output logic                reg_write_en,
  output logic [XLEN-1:0]     pc,
  output logic [31:0]         instret,
  output logic                busy,
  output logic                halted,
  output logic                illegal
);
  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     instret_q, instret_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic            rd_nonzero_q, rd_nonzero_d;
  logic            reg_we_q, reg_we_d;
  logic            illegal_q, illegal_d;

  logic [3:0] dec_alu_op;
  logic       dec_is_legal;
  logic       dec_is_ecall;
  logic       dec_rd_nonzero;

  instr_decoder u_decoder (
    .instr      (instr_q),
    .alu_op     (dec_alu_op),
    .is_legal   (dec_is_legal),
    .is_ecall   (dec_is_ecall),
    .rd_nonzero (dec_rd_nonzero)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instret_d    = instret_q;
    alu_op_d     = alu_op_q;
    rd_nonzero_d = rd_nonzero_q;
    reg_we_d     = 1'b0;
    illegal_d    = illegal_q;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (dec_is_ecall) begin
          state_d = StHalt;
        end else if (dec_is_legal) begin
          alu_op_d     = dec_alu_op;
          rd_nonzero_d = dec_rd_nonzero;
          state_d      = StExecute;
        end else begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end
      end
      StExecute: begin
        // Strobe is a flop: arm it on the way into writeback, never for x0.
        reg_we_d = rd_nonzero_q;
        state_d  = StWriteback;
      end
      StWriteback: begin
        pc_d      = pc_q + XLEN'(4);
        instret_d = instret_q + 32'd1;
        state_d   = run ? StFetch : StIdle;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      instr_q      <= 32'h0;
      instret_q    <= 32'h0;
      alu_op_q     <= ALU_ADD;
      rd_nonzero_q <= 1'b0;
      reg_we_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instret_q    <= instret_d;
      alu_op_q     <= alu_op_d;
      rd_nonzero_q <= rd_nonzero_d;
      reg_we_q     <= reg_we_d;
      illegal_q    <= illegal_d;
    end
  end

  assign imem.imem_req  = (state_q == StFetch);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign alu_op         = alu_op_q;
  assign reg_write_en   = reg_we_q;
  assign pc             = pc_q;
  assign instret        = instret_q;
  assign busy           = (state_q != StIdle) && (state_q != StHalt);
  assign halted         = (state_q == StHalt);
  assign illegal        = illegal_q;
endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer against a per-instruction transaction model.
module tb_core_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  logic run;

  logic [31:0] instr, instr_w;
  logic [3:0]  alu_op, alu_op_w;
  logic        reg_write_en, reg_write_en_w;
  logic [31:0] pc, pc_w;
  logic [31:0] instret, instret_w;
  logic        busy, busy_w, halted, halted_w, illegal, illegal_w;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_instret;
  bit          last_halted;

  core_sequencer_if #(.XLEN(32)) imem_if ();
  core_sequencer_if #(.XLEN(32)) wrap_if ();

  // Zero-wait memory for the wrap instance, always returning add x3,x1,x2.
  assign wrap_if.imem_ready = wrap_if.imem_req;
  assign wrap_if.imem_rdata = 32'h0020_81B3;

  core_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .imem         (imem_if),
    .instr        (instr),
    .alu_op       (alu_op),
    .reg_write_en (reg_write_en),
    .pc           (pc),
    .instret      (instret),
    .busy         (busy),
    .halted       (halted),
    .illegal      (illegal)
  );

  core_sequencer #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .imem         (wrap_if),
    .instr        (instr_w),
    .alu_op       (alu_op_w),
    .reg_write_en (reg_write_en_w),
    .pc           (pc_w),
    .instret      (instret_w),
    .busy         (busy_w),
    .halted       (halted_w),
    .illegal      (illegal_w)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural meaning of an instruction word, straight from the ISA rules.
  function automatic void ref_decode(input logic [31:0] w, output bit legal, output bit ecall,
                                     output int op);
    int base_op [8];
    base_op = '{0, 2, 3, 4, 5, 6, 8, 9};
    ecall = (w == 32'h0000_0073);
    legal = 1'b0;
    op    = 0;
    if (w[6:0] == 7'b0110011) begin
      if (w[31:25] == 7'h00) begin
        legal = 1'b1;
        op    = base_op[w[14:12]];
      end else if (w[31:25] == 7'h20 && (w[14:12] == 3'd0 || w[14:12] == 3'd5)) begin
        legal = 1'b1;
        op    = (w[14:12] == 3'd0) ? 1 : 7;
      end
    end
  endfunction

  function automatic logic [31:0] gen_word();
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] w;
    int          k;
    k  = int'($urandom_range(0, 9));
    f3 = 3'($urandom);
    f7 = 7'h00;
    rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    if (k == 4) begin
      f7 = 7'h20;
      f3 = 3'd0;
    end else if (k == 5) begin
      f7 = 7'h20;
      f3 = 3'd5;
    end else if (k == 7) begin
      f7 = 7'h20;
      f3 = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd6;
    end else if (k == 8) begin
      f7 = 7'($urandom);
    end
    w = {f7, 5'($urandom), 5'($urandom), f3, rd, 7'b0110011};
    if (k == 6) w = 32'h0000_0073;
    if (k == 9) w = $urandom;
    return w;
  endfunction

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".pc"}, pc, 32'h0);
    check_eq({tag, ".instr"}, instr, 32'h0);
    check_eq({tag, ".alu_op"}, alu_op, 4'd0);
    check_eq({tag, ".instret"}, instret, 32'h0);
    check_eq({tag, ".req"}, imem_if.imem_req, 1'b0);
    check_eq({tag, ".we"}, reg_write_en, 1'b0);
    check_eq({tag, ".busy"}, busy, 1'b0);
    check_eq({tag, ".halted"}, halted, 1'b0);
    check_eq({tag, ".illegal"}, illegal, 1'b0);
    exp_pc      = 32'h0;
    exp_instret = 32'h0;
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    run   = 1'b0;
    imem_if.imem_ready = 1'b0;
    step();
    check_reset_values(tag);
    rst_n = 1'b1;
  endtask

  // Entry: sample point with the DUT fetching. drop_at 1/2 lowers run in DECODE/EXECUTE.
  task automatic exec_instr(input logic [31:0] word, input int unsigned wait_n,
                            input int drop_at, input bit run_next);
    bit legal, ecall;
    int op;
    ref_decode(word, legal, ecall, op);
    last_halted = 1'b0;
    check_eq("fetch.req", imem_if.imem_req, 1'b1);
    check_eq("fetch.addr", imem_if.imem_addr, exp_pc);
    for (int i = 0; i < int'(wait_n); i++) begin
      imem_if.imem_ready = 1'b0;
      imem_if.imem_rdata = $urandom;
      step();
      check_eq("wait.req", imem_if.imem_req, 1'b1);
      check_eq("wait.addr", imem_if.imem_addr, exp_pc);
    end
    imem_if.imem_ready = 1'b1;
    imem_if.imem_rdata = word;
    step();
    // Stray ready/data outside a fetch must not disturb the latched instruction.
    imem_if.imem_ready = 1'($urandom);
    imem_if.imem_rdata = $urandom;
    check_eq("decode.req", imem_if.imem_req, 1'b0);
    check_eq("decode.instr", instr, word);
    check_eq("decode.busy", busy, 1'b1);
    if (drop_at == 1) run = 1'b0;
    step();
    if (ecall || !legal) begin
      check_eq("halt.halted", halted, 1'b1);
      check_eq("halt.illegal", illegal, !ecall);
      check_eq("halt.busy", busy, 1'b0);
      check_eq("halt.pc", pc, exp_pc);
      check_eq("halt.instret", instret, exp_instret);
      imem_if.imem_ready = 1'b0;
      last_halted = 1'b1;
      return;
    end
    check_eq("exec.alu_op", alu_op, op);
    check_eq("exec.we", reg_write_en, 1'b0);
    check_eq("exec.instr", instr, word);
    if (drop_at == 2) run = 1'b0;
    step();
    check_eq("wb.we", reg_write_en, word[11:7] != 5'd0);
    check_eq("wb.alu_op", alu_op, op);
    check_eq("wb.pc", pc, exp_pc);
    run = run_next;
    step();
    exp_pc      = exp_pc + 32'd4;
    exp_instret = exp_instret + 32'd1;
    imem_if.imem_ready = 1'b0;
    check_eq("retire.pc", pc, exp_pc);
    check_eq("retire.instret", instret, exp_instret);
    check_eq("retire.we", reg_write_en, 1'b0);
    check_eq("retire.req", imem_if.imem_req, run_next);
    check_eq("retire.busy", busy, run_next);
  endtask

  task automatic start_fetch();
    run = 1'b1;
    step();
  endtask

  task automatic poke_halted(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      run = 1'($urandom);
      imem_if.imem_ready = 1'($urandom);
      imem_if.imem_rdata = $urandom;
      step();
      check_eq("halt.sticky", halted, 1'b1);
      check_eq("halt.req", imem_if.imem_req, 1'b0);
      check_eq("halt.hold_pc", pc, exp_pc);
    end
    imem_if.imem_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    imem_if.imem_ready = 1'b0;
    imem_if.imem_rdata = 32'h0;
    exp_pc      = 32'h0;
    exp_instret = 32'h0;
    last_halted = 1'b0;
    step();
    apply_reset("reset");

    // add x3,x1,x2 with zero-wait memory; the wrap instance runs in lockstep.
    start_fetch();
    check_eq("wrap.addr", wrap_if.imem_addr, 32'hFFFF_FFFC);
    exec_instr(32'h0020_81B3, 0, 0, 1'b0);
    check_eq("wrap.pc", pc_w, 32'h0);
    check_eq("wrap.instret", instret_w, 32'd1);

    start_fetch();
    exec_instr(32'h4020_81B3, 3, 0, 1'b0);

    apply_reset("reset_x0");
    start_fetch();
    exec_instr(32'h0020_8033, 1, 0, 1'b0);

    // Run dropped in EXECUTE still retires, then idles.
    start_fetch();
    exec_instr(32'h0020_C1B3, 0, 2, 1'b0);
    step();
    check_eq("idle.busy", busy, 1'b0);
    check_eq("idle.pc", pc, exp_pc);

    start_fetch();
    exec_instr(32'h0000_0013, 2, 0, 1'b0);
    poke_halted(6);
    apply_reset("reset_illegal");

    start_fetch();
    exec_instr(32'h0000_0073, 0, 0, 1'b0);
    poke_halted(3);
    apply_reset("reset_ecall");

    // Reset mid-fetch abandons the request; a late ready is ignored.
    start_fetch();
    step();
    check_eq("midfetch.req", imem_if.imem_req, 1'b1);
    rst_n = 1'b0;
    step();
    check_eq("midfetch.req_drop", imem_if.imem_req, 1'b0);
    rst_n = 1'b1;
    run   = 1'b0;
    imem_if.imem_ready = 1'b1;
    imem_if.imem_rdata = 32'h0020_81B3;
    step();
    check_eq("late.instr", instr, 32'h0);
    check_eq("late.busy", busy, 1'b0);
    imem_if.imem_ready = 1'b0;

    begin
      bit fetching;
      fetching = 1'b0;
      for (int n = 0; n < 150; n++) begin
        if (!fetching) start_fetch();
        fetching = ($urandom_range(0, 3) != 0);
        exec_instr(gen_word(), $urandom_range(0, 3), int'($urandom_range(0, 4)), fetching);
        if (last_halted) begin
          poke_halted(2);
          apply_reset("rand_reset");
          fetching = 1'b0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
